// File: rtl/sb_serializer_pkg.sv
// Shared sideband definitions: line-level constants, serializer FSM encoding
// and the per-state line level driven onto the serial wire.
package sb_serializer_pkg;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_GAP
  } sb_state_e;

  // Level the line must carry while the FSM sits in a given state.
  function automatic logic line_level(input sb_state_e state, input logic payload_lsb);
    case (state)
      ST_START: line_level = START_BIT;
      ST_DATA:  line_level = payload_lsb;
      ST_STOP:  line_level = STOP_BIT;
      default:  line_level = IDLE_LEVEL;
    endcase
  endfunction

endpackage

// File: rtl/sb_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; pushes while full and
// pops while empty are ignored.
module sb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = wr_en && !full;
  assign w_pop  = rd_en && !empty;

  // NOTE: storage is deliberately not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;
  assign full    = (r_count == CW'(DEPTH));
  assign empty   = (r_count == '0);

endmodule

// File: rtl/sb_serializer.sv
// Sideband serializer: buffers parallel words and sends each as a
// start / LSB-first payload / stop frame with an optional idle gap.
module sb_serializer
  import sb_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int IDLE_GAP   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic                          serial_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BCW        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int GCW        = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam int LAST_GAP_I = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);
  localparam logic [GCW-1:0] LAST_GAP = GCW'(LAST_GAP_I);

  sb_state_e             r_state;
  sb_state_e             w_next_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BCW-1:0]        r_bit_cnt;
  logic [GCW-1:0]        r_gap_cnt;
  logic                  r_serial_out;

  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_fifo_rd_data;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_count;

  assign w_push = data_valid && data_ready;

  sb_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_push),
    .wr_data (data_in),
    .rd_en   (w_pop),
    .rd_data (w_fifo_rd_data),
    .count   (w_fifo_count),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_next_state = ST_START;
        end
      end
      ST_START: w_next_state = ST_DATA;
      ST_DATA: begin
        if (r_bit_cnt == LAST_BIT) w_next_state = ST_STOP;
      end
      ST_STOP: begin
        if (IDLE_GAP > 0) begin
          w_next_state = ST_GAP;
        end else if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_next_state = ST_START;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == LAST_GAP) begin
          if (!w_fifo_empty) begin
            w_pop        = 1'b1;
            w_next_state = ST_START;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_serial_out <= IDLE_LEVEL;
    end else begin
      r_state      <= w_next_state;
      // Line lags the state by one cycle so serial_out comes straight from a flop.
      r_serial_out <= line_level(r_state, r_shift[0]);

      if (w_pop) begin
        r_shift <= w_fifo_rd_data;
      end else if (r_state == ST_DATA) begin
        r_shift <= r_shift >> 1;
      end

      if (r_state == ST_DATA) begin
        r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + 1'b1;
      end

      if (r_state == ST_GAP) begin
        r_gap_cnt <= (r_gap_cnt == LAST_GAP) ? '0 : r_gap_cnt + 1'b1;
      end
    end
  end

  assign serial_out = r_serial_out;
  assign data_ready = !w_fifo_full;
  assign fifo_count = w_fifo_count;
  assign busy       = (r_state != ST_IDLE) || (w_fifo_count != '0);

endmodule

// File: doc/sb_serializer.md
SB_SERIALIZER -- requirements
Module: sb_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: payload bits per frame.
REQ-002 Parameter FIFO_DEPTH, default 4: entries in the input buffer; power of two, at least 2.
REQ-003 Parameter IDLE_GAP, default 0: extra idle-high cycles inserted after each stop bit.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 data_in  input  DATA_WIDTH  payload word to transmit.
REQ-007 data_valid  input  1  data_in is offered this cycle.
REQ-008 data_ready  output  1  buffer can accept a word this cycle.
REQ-009 serial_out  output  1  sideband line; idle level 1.
REQ-010 busy  output  1  frame in flight or buffer non-empty.
REQ-011 fifo_count  output  clog2(FIFO_DEPTH)+1  current buffer occupancy.

Function
REQ-012 A word SHALL be accepted on a rising edge where data_valid=1 and data_ready=1.
REQ-013 data_ready SHALL equal (fifo_count != FIFO_DEPTH), with no same-cycle pop bypass.
REQ-014 Frame SHALL be DATA_WIDTH+2 bits, one bit per cycle: start bit 0, payload LSB first, stop bit 1.
REQ-015 Frame format SHALL match the downstream deserializer with WIDTH=DATA_WIDTH+2.
REQ-016 FSM states SHALL be IDLE, START, DATA, STOP and GAP.
REQ-017 IDLE->START: the FSM SHALL pop the FIFO head into a shift register when the FIFO is non-empty.
REQ-018 START->DATA, DATA->STOP and STOP transitions SHALL each take one cycle per bit; DATA lasts DATA_WIDTH cycles, counted by a bit counter.
REQ-019 STOP SHALL go to GAP if IDLE_GAP>0; otherwise, if the FIFO is non-empty, it SHALL pop and go to START, else go to IDLE.
REQ-020 GAP SHALL last IDLE_GAP cycles with serial_out=1, then follow the STOP-exit rule of REQ-019.
REQ-021 serial_out SHALL be registered: a word accepted at edge N into an empty, idle block drives the start bit from edge N+2.
REQ-022 With IDLE_GAP=0 and a non-empty FIFO, frames SHALL be back-to-back: a start bit directly follows the stop bit.
REQ-023 A simultaneous push and pop SHALL leave fifo_count unchanged and keep data in order.
REQ-024 A push while full SHALL be impossible (data_ready=0); data_in is ignored.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 busy SHALL equal (state != IDLE) or (fifo_count != 0).

Reset
REQ-027 While rst=1 at an edge, the block SHALL apply reset values: state=IDLE, serial_out=1, fifo_count=0, pointers=0, bit counter=0, busy=0, data_ready=1.
REQ-028 Reset mid-frame SHALL abort the frame and drop all buffered words.
REQ-029 No partial frame SHALL be emitted after reset.

Structure
REQ-030 Frame constants (START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1) and the FSM state encoding SHALL live in the shared sideband package.
REQ-031 The buffer SHALL be one sub-module, sb_sync_fifo, with ports clk, rst, wr_en, wr_data, rd_en, rd_data, count, full and empty.
REQ-032 The FSM, shift register and bit counter SHALL reside in sb_serializer.

Verification
REQ-033 Push 0xA5 into an idle block -> serial_out from edge N+2 = 0,1,0,1,0,0,1,0,1,1, then stays 1; busy falls after the stop bit.
REQ-034 Loopback serial_out into deserializer(WIDTH=10), push 0xA5 -> parallel_data=10'h34A.
REQ-035 Push 0x00 and 0xFF on consecutive cycles, IDLE_GAP=0 -> 20 contiguous line bits: 0,8x0,1,0,8x1,1.
REQ-036 Hold data_valid=1 for 8 cycles with values 0x01..0x08 -> data_ready drops when fifo_count=4; every accepted word is transmitted once, in order; none is duplicated.
REQ-037 Assert rst during the 3rd payload bit with 2 words buffered -> next cycle serial_out=1, fifo_count=0, data_ready=1; line stays 1 until a new push.
REQ-038 IDLE_GAP=2, push 0x3C twice -> exactly 2 idle-high cycles between the first stop bit and the second start bit.
